// File: rtl/cp0_reg_file_if.sv
// Pipeline-facing bus of the CP0 register file: read port, MTC0 write port,
// exception/ERET commit, interrupt lines and the architectural state taps.
interface cp0_reg_file_if;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [2:0]  wb_wsel;
  logic [31:0] wb_wdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_ds;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] ebase_o;
  logic        int_req;

  modport master (
    output rd_addr, rd_sel, wb_we, wb_waddr, wb_wsel, wb_wdata,
           exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret, hw_int,
    input  rd_data, status_o, cause_o, epc_o, ebase_o, int_req
  );

  modport slave (
    input  rd_addr, rd_sel, wb_we, wb_waddr, wb_wsel, wb_wdata,
           exc_valid, exc_code, exc_pc, exc_in_ds, exc_badvaddr, eret, hw_int,
    output rd_data, status_o, cause_o, epc_o, ebase_o, int_req
  );
endinterface

// File: rtl/cp0_reg_file.sv
// Architectural CP0 register file: committed state, MTC0 writes from WB,
// exception/ERET commits from MM, and the Count/Compare timer with interrupt request.
module cp0_reg_file #(
  parameter logic [31:0] PRID_VAL   = 32'h00018000,
  parameter logic [31:0] CONFIG_VAL = 32'h80000000,
  parameter logic [31:0] EBASE_RST  = 32'h80000000
) (
  input  logic            clk,
  input  logic            rst_n,
  cp0_reg_file_if.slave   bus
);

  localparam logic [31:0] STATUS_RST   = 32'h00400000;
  localparam logic [31:0] STATUS_WMASK = 32'h0040FF03;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFFF000;

  localparam logic [7:0] R_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] R_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] R_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] R_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] R_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] R_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] R_PRID     = {5'd15, 3'd0};
  localparam logic [7:0] R_EBASE    = {5'd15, 3'd1};
  localparam logic [7:0] R_CONFIG   = {5'd16, 3'd0};

  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] ebase;
  logic        cause_bd;
  logic        cause_ti;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic        tog;

  logic [7:0]  waddr;
  logic        we_count, we_compare, we_status, we_cause, we_epc, we_ebase;
  logic [31:0] count_inc;
  logic        ti_next;
  logic [31:0] cause;

  assign waddr      = {bus.wb_waddr, bus.wb_wsel};
  assign we_count   = bus.wb_we && (waddr == R_COUNT);
  assign we_compare = bus.wb_we && (waddr == R_COMPARE);
  assign we_status  = bus.wb_we && (waddr == R_STATUS);
  assign we_cause   = bus.wb_we && (waddr == R_CAUSE);
  assign we_epc     = bus.wb_we && (waddr == R_EPC);
  assign we_ebase   = bus.wb_we && (waddr == R_EBASE);

  assign count_inc = count + 32'd1;

  // A Compare write always clears TI, even against a simultaneous match; a
  // Count write suppresses the increment and therefore any match.
  always_comb begin
    ti_next = cause_ti;
    if (we_compare)
      ti_next = 1'b0;
    else if (tog && !we_count && (count_inc == compare))
      ti_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      badvaddr  <= '0;
      count     <= '0;
      compare   <= '0;
      status    <= STATUS_RST;
      epc       <= '0;
      ebase     <= EBASE_RST;
      cause_bd  <= 1'b0;
      cause_ti  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      tog       <= 1'b0;
    end else begin
      tog <= we_count ? 1'b0 : ~tog;
      if (we_count)
        count <= bus.wb_wdata;
      else if (tog)
        count <= count_inc;
      if (we_compare)
        compare <= bus.wb_wdata;
      cause_ti      <= ti_next;
      cause_ip[7:2] <= {bus.hw_int[5] | ti_next, bus.hw_int[4:0]};
      if (we_cause)
        cause_ip[1:0] <= bus.wb_wdata[9:8];
      if (we_status)
        status <= (status & ~STATUS_WMASK) | (bus.wb_wdata & STATUS_WMASK);
      if (we_epc)
        epc <= bus.wb_wdata;
      if (we_ebase)
        ebase <= (ebase & ~EBASE_WMASK) | (bus.wb_wdata & EBASE_WMASK);

      // Commit events come after the MTC0 write so their fields take priority.
      if (bus.exc_valid) begin
        cause_exc <= bus.exc_code;
        if (!status[1]) begin
          epc      <= bus.exc_in_ds ? (bus.exc_pc - 32'd4) : bus.exc_pc;
          cause_bd <= bus.exc_in_ds;
        end
        status[1] <= 1'b1;
        if ((bus.exc_code == 5'd4) || (bus.exc_code == 5'd5))
          badvaddr <= bus.exc_badvaddr;
      end else if (bus.eret) begin
        status[1] <= 1'b0;
      end
    end
  end

  assign cause = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};

  always_comb begin
    bus.rd_data = '0;
    case ({bus.rd_addr, bus.rd_sel})
      R_BADVADDR: bus.rd_data = badvaddr;
      R_COUNT:    bus.rd_data = count;
      R_COMPARE:  bus.rd_data = compare;
      R_STATUS:   bus.rd_data = status;
      R_CAUSE:    bus.rd_data = cause;
      R_EPC:      bus.rd_data = epc;
      R_PRID:     bus.rd_data = PRID_VAL;
      R_EBASE:    bus.rd_data = ebase;
      R_CONFIG:   bus.rd_data = CONFIG_VAL;
      default:    bus.rd_data = '0;
    endcase
  end

  assign bus.status_o = status;
  assign bus.cause_o  = cause;
  assign bus.epc_o    = epc;
  assign bus.ebase_o  = ebase;
  assign bus.int_req  = status[0] & ~status[1] & (|(cause_ip & status[15:8]));

endmodule

// File: tb/tb_cp0_reg_file.sv
// Bench for cp0_reg_file: directed scenarios against fixed values, then
// randomized traffic against an architectural reference model.
module tb_cp0_reg_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cp0_reg_file_if bus();

  cp0_reg_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (architectural register words).
  logic [31:0] m_badv, m_count, m_compare, m_status, m_cause, m_epc, m_ebase;
  bit          m_tog;
  logic [31:0] x_badv, x_count, x_compare, x_status, x_cause, x_epc, x_ebase;
  bit          x_tog;

  task automatic model_step();
    int r;
    bit wr, cnt_wr, cmp_wr, ti;
    logic [31:0] wd;
    r  = int'({bus.wb_waddr, bus.wb_wsel});
    wr = bus.wb_we;
    wd = bus.wb_wdata;
    if (!rst_n) begin
      x_badv = 0; x_count = 0; x_compare = 0; x_status = 32'h00400000;
      x_cause = 0; x_epc = 0; x_ebase = 32'h80000000; x_tog = 0;
      return;
    end
    cnt_wr    = wr && r == 72;
    cmp_wr    = wr && r == 88;
    x_tog     = cnt_wr ? 1'b0 : !m_tog;
    x_count   = cnt_wr ? wd : m_count + (m_tog ? 32'd1 : 32'd0);
    x_compare = cmp_wr ? wd : m_compare;
    ti = m_cause[30];
    if (cmp_wr) ti = 0;
    else if (!cnt_wr && m_tog && x_count == m_compare) ti = 1;
    x_cause = m_cause;
    x_cause[30] = ti;
    x_cause[15] = bus.hw_int[5] | ti;
    x_cause[14:10] = bus.hw_int[4:0];
    if (wr && r == 104) x_cause[9:8] = wd[9:8];
    x_status = m_status;
    if (wr && r == 96) x_status = (m_status & ~32'h0040FF03) | (wd & 32'h0040FF03);
    x_epc = (wr && r == 112) ? wd : m_epc;
    x_ebase = m_ebase;
    if (wr && r == 121) x_ebase[29:12] = wd[29:12];
    x_badv = m_badv;
    if (bus.exc_valid) begin
      x_cause[6:2] = bus.exc_code;
      if (!m_status[1]) begin
        x_epc = bus.exc_in_ds ? bus.exc_pc - 32'd4 : bus.exc_pc;
        x_cause[31] = bus.exc_in_ds;
      end
      x_status[1] = 1'b1;
      if (bus.exc_code == 5'd4 || bus.exc_code == 5'd5) x_badv = bus.exc_badvaddr;
    end else if (bus.eret) begin
      x_status[1] = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_read(int r);
    case (r)
      64: return m_badv;
      72: return m_count;
      88: return m_compare;
      96: return m_status;
      104: return m_cause;
      112: return m_epc;
      120: return 32'h00018000;
      121: return m_ebase;
      128: return 32'h80000000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit model_int();
    return m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    m_badv = x_badv; m_count = x_count; m_compare = x_compare; m_status = x_status;
    m_cause = x_cause; m_epc = x_epc; m_ebase = x_ebase; m_tog = x_tog;
  endtask

  task automatic idle();
    bus.wb_we = 0; bus.exc_valid = 0; bus.eret = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.wb_we = 1; bus.wb_waddr = a; bus.wb_wsel = s; bus.wb_wdata = d;
    tick();
    bus.wb_we = 0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] s, output logic [31:0] d);
    bus.rd_addr = a; bus.rd_sel = s;
    #1;
    d = bus.rd_data;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [4:0]  ra [10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd15, 5'd16, 5'd0};
    logic [2:0]  rs [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    logic [31:0] ev [10] = '{32'h0, 32'h0, 32'h0, 32'h00400000, 32'h0, 32'h0,
                             32'h00018000, 32'h80000000, 32'h80000000, 32'h0};
    rst_n = 0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      rd(ra[i], rs[i], v);
      n_cmp++;
      if (v !== ev[i]) begin
        n_bad++;
        $display("FAIL reset_read %0d/%0d: got %h want %h", ra[i], rs[i], v, ev[i]);
      end
    end
    n_cmp++;
    if (bus.int_req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_int_req: got %b want 0", bus.int_req);
    end
    rst_n = 1;
  endtask

  task automatic test_status_cause();
    logic [31:0] v;
    wr(5'd12, 3'd0, 32'hFFFFFFFF);
    rd(5'd12, 3'd0, v);
    n_cmp++;
    if (v !== 32'h0040FF03) begin
      n_bad++; $display("FAIL status_mask: got %h want 0040ff03", v);
    end
    wr(5'd13, 3'd0, 32'hFFFFFFFF);
    rd(5'd13, 3'd0, v);
    n_cmp++;
    if (v !== 32'h00000300) begin
      n_bad++; $display("FAIL cause_mask: got %h want 00000300", v);
    end
    wr(5'd12, 3'd0, 32'h00400101);
    n_cmp++;
    if (bus.int_req !== 1'b1) begin
      n_bad++; $display("FAIL sw_int_req: got %b want 1", bus.int_req);
    end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    wr(5'd11, 3'd0, 32'd10);
    wr(5'd9, 3'd0, 32'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      rd(5'd9, 3'd0, v);
      n_cmp++;
      if (v !== 32'(i / 2)) begin
        n_bad++; $display("FAIL timer_count i=%0d: got %0d want %0d", i, v, i / 2);
      end
      if (i >= 19) begin
        n_cmp++;
        if (bus.cause_o[30] !== (i == 20)) begin
          n_bad++; $display("FAIL timer_ti i=%0d: got %b want %b", i, bus.cause_o[30], i == 20);
        end
      end
    end
    wr(5'd11, 3'd0, 32'd100);
    n_cmp++;
    if (bus.cause_o[30] !== 1'b0) begin
      n_bad++; $display("FAIL ti_clear: got %b want 0", bus.cause_o[30]);
    end
    wr(5'd9, 3'd0, 32'hFFFFFFFF);
    rd(5'd9, 3'd0, v);
    n_cmp++;
    if (v !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL count_write: got %h want ffffffff", v);
    end
    tick();
    tick();
    rd(5'd9, 3'd0, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_bad++; $display("FAIL count_wrap: got %h want 0", v);
    end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    bus.exc_valid = 1; bus.exc_code = 5'd4; bus.exc_pc = 32'hBFC00104;
    bus.exc_in_ds = 1; bus.exc_badvaddr = 32'h12345677;
    tick();
    idle();
    rd(5'd8, 3'd0, v);
    n_cmp++;
    if (bus.epc_o !== 32'hBFC00100 || bus.cause_o[31] !== 1'b1 || bus.cause_o[6:2] !== 5'd4 ||
        bus.status_o[1] !== 1'b1 || v !== 32'h12345677) begin
      n_bad++;
      $display("FAIL exc_first: got epc=%h cause=%h status=%h badv=%h want epc=bfc00100 bd=1 exc=4 exl=1 badv=12345677",
               bus.epc_o, bus.cause_o, bus.status_o, v);
    end
    bus.exc_valid = 1; bus.exc_code = 5'd8; bus.exc_pc = 32'h80000000;
    bus.exc_in_ds = 0; bus.exc_badvaddr = 32'h0;
    tick();
    idle();
    rd(5'd8, 3'd0, v);
    n_cmp++;
    if (bus.epc_o !== 32'hBFC00100 || bus.cause_o[31] !== 1'b1 || bus.cause_o[6:2] !== 5'd8 ||
        v !== 32'h12345677) begin
      n_bad++;
      $display("FAIL exc_nested: got epc=%h cause=%h badv=%h want epc=bfc00100 bd=1 exc=8 badv=12345677",
               bus.epc_o, bus.cause_o, v);
    end
  endtask

  task automatic test_simultaneous();
    bus.eret = 1;
    tick();
    idle();
    n_cmp++;
    if (bus.status_o[1] !== 1'b0) begin
      n_bad++; $display("FAIL eret_clear: got exl=%b want 0", bus.status_o[1]);
    end
    bus.wb_we = 1; bus.wb_waddr = 5'd14; bus.wb_wsel = 3'd0; bus.wb_wdata = 32'hDEADBEEF;
    bus.exc_valid = 1; bus.exc_code = 5'd0; bus.exc_pc = 32'h80001000; bus.exc_in_ds = 0;
    tick();
    idle();
    n_cmp++;
    if (bus.epc_o !== 32'h80001000) begin
      n_bad++; $display("FAIL mtc0_vs_exc_epc: got %h want 80001000", bus.epc_o);
    end
    bus.eret = 1; bus.exc_valid = 1;
    tick();
    idle();
    n_cmp++;
    if (bus.status_o[1] !== 1'b1) begin
      n_bad++; $display("FAIL eret_vs_exc: got exl=%b want 1", bus.status_o[1]);
    end
    bus.eret = 1;
    tick();
    idle();
    n_cmp++;
    if (bus.status_o[1] !== 1'b0) begin
      n_bad++; $display("FAIL eret_alone: got exl=%b want 0", bus.status_o[1]);
    end
  endtask

  task automatic test_hw_int();
    logic [31:0] v;
    bus.hw_int = 6'b100000;
    #1;
    n_cmp++;
    if (bus.cause_o[15] !== 1'b0) begin
      n_bad++; $display("FAIL hw_int_latency: got ip7=%b want 0", bus.cause_o[15]);
    end
    tick();
    n_cmp++;
    if (bus.cause_o[15] !== 1'b1) begin
      n_bad++; $display("FAIL hw_int_ip7: got ip7=%b want 1", bus.cause_o[15]);
    end
    wr(5'd12, 3'd0, 32'h00408001);
    n_cmp++;
    if (bus.int_req !== 1'b1) begin
      n_bad++; $display("FAIL hw_int_req: got %b want 1", bus.int_req);
    end
    rst_n = 0;
    bus.exc_valid = 1; bus.exc_code = 5'd5; bus.exc_badvaddr = 32'hCAFEF00D;
    bus.wb_we = 1; bus.wb_waddr = 5'd14; bus.wb_wsel = 3'd0; bus.wb_wdata = 32'h12340000;
    tick();
    idle();
    rd(5'd8, 3'd0, v);
    n_cmp++;
    if (bus.status_o !== 32'h00400000 || bus.cause_o !== 32'h0 || bus.epc_o !== 32'h0 ||
        bus.ebase_o !== 32'h80000000 || bus.int_req !== 1'b0 || v !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got status=%h cause=%h epc=%h ebase=%h int=%b badv=%h",
               bus.status_o, bus.cause_o, bus.epc_o, bus.ebase_o, bus.int_req, v);
    end
    rd(5'd9, 3'd0, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_bad++; $display("FAIL mid_reset_count: got %h want 0", v);
    end
    rst_n = 1;
    bus.hw_int = 6'b0;
  endtask

  task automatic test_random();
    int regs [10] = '{64, 72, 88, 96, 104, 112, 120, 121, 128, 0};
    int r;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      bus.wb_we = ($urandom_range(0, 2) == 0);
      r = regs[$urandom_range(0, 9)];
      if (r == 0) r = int'($urandom_range(0, 255));
      bus.wb_waddr = 5'(r >> 3);
      bus.wb_wsel = 3'(r & 7);
      bus.wb_wdata = $urandom;
      if (r == 88) bus.wb_wdata = m_count + $urandom_range(0, 6);
      bus.exc_valid = ($urandom_range(0, 7) == 0);
      bus.exc_code = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom_range(0, 31));
      bus.exc_pc = $urandom;
      bus.exc_in_ds = 1'($urandom_range(0, 1));
      bus.exc_badvaddr = $urandom;
      bus.eret = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) bus.hw_int = 6'($urandom_range(0, 63));
      tick();
      r = regs[$urandom_range(0, 9)];
      if (r == 0) r = int'($urandom_range(0, 255));
      bus.rd_addr = 5'(r >> 3);
      bus.rd_sel = 3'(r & 7);
      #1;
      n_cmp++;
      if (bus.rd_data !== model_read(r)) begin
        n_bad++; $display("FAIL rand_rd c=%0d reg %0d: got %h want %h", c, r, bus.rd_data, model_read(r));
      end
      n_cmp++;
      if (bus.status_o !== m_status || bus.cause_o !== m_cause || bus.epc_o !== m_epc ||
          bus.ebase_o !== m_ebase || bus.int_req !== model_int()) begin
        n_bad++;
        $display("FAIL rand_taps c=%0d: got st=%h ca=%h epc=%h eb=%h int=%b want st=%h ca=%h epc=%h eb=%h int=%b",
                 c, bus.status_o, bus.cause_o, bus.epc_o, bus.ebase_o, bus.int_req,
                 m_status, m_cause, m_epc, m_ebase, model_int());
      end
    end
    rst_n = 1;
    idle();
  endtask

  initial begin
    bus.rd_addr = 0; bus.rd_sel = 0; bus.wb_we = 0; bus.wb_waddr = 0; bus.wb_wsel = 0;
    bus.wb_wdata = 0; bus.exc_valid = 0; bus.exc_code = 0; bus.exc_pc = 0;
    bus.exc_in_ds = 0; bus.exc_badvaddr = 0; bus.eret = 0; bus.hw_int = 0;
    m_badv = 0; m_count = 0; m_compare = 0; m_status = 0; m_cause = 0;
    m_epc = 0; m_ebase = 0; m_tog = 0;
    test_reset();
    test_status_cause();
    test_timer();
    test_exception();
    test_simultaneous();
    test_hw_int();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
